// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin 8:1 mux arbiter.
package mux_arb_pkg;

    localparam int NREQ = 8;
    localparam int DW   = 3;
    localparam int SELW = 3;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot_sel(input logic [SELW-1:0] idx);
        logic [NREQ-1:0] v;
        v = {{(NREQ-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping mod 8.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            any,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] cand_s;

    // Scan from the farthest offset down so the nearest set request wins last.
    always_comb begin
        any    = 1'b0;
        idx    = ptr;
        cand_s = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_s = ptr + SELW'(k);
            idx    = req[cand_s] ? cand_s : idx;
            any    = any | req[cand_s];
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin sequencer sharing one external 8:1 mux among eight requesters,
// with a registered holding word presented on a valid/ready handshake.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [SELW-1:0] sel3,
    input  logic [DW-1:0]   mux_out,
    output logic [NREQ-1:0] gnt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [SELW-1:0] out_src
);

    arb_state_t      state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] sel3_q, sel3_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [SELW-1:0] out_src_q, out_src_d;
    logic            pick_any_s;
    logic [SELW-1:0] pick_idx_s;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    // Next-state and datapath control; gnt is armed in ARB so it is high during LOAD only.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel3_d      = sel3_q;
        gnt_d       = {NREQ{1'b0}};
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        case (state_q)
            ARB: begin
                if (pick_any_s) begin
                    sel3_d    = pick_idx_s;
                    out_src_d = pick_idx_s;
                    gnt_d     = onehot_sel(pick_idx_s);
                    state_d   = LOAD;
                end else begin
                    state_d   = ARB;
                end
            end
            LOAD: begin
                out_data_d  = mux_out;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    ptr_d       = out_src_q + 3'd1;
                    state_d     = ARB;
                end else begin
                    state_d     = SEND;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ARB;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            ptr_q       <= 3'd0;
            sel3_q      <= 3'd0;
            gnt_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 3'd0;
            out_src_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel3_q      <= sel3_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign sel3      = sel3_q;
    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed and random checks of mux8_rr_arbiter and its rr_pick8 encoder.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] sel3;
    logic [2:0] mux_out;
    logic [7:0] gnt;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic [2:0] out_src;
    logic [2:0] in_data [8];

    logic [7:0] pk_req;
    logic [2:0] pk_ptr;
    logic       pk_any;
    logic [2:0] pk_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mux_out = in_data[sel3];

    mux8_rr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .sel3      (sel3),
        .mux_out   (mux_out),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    rr_pick8 u_pick_tb (
        .req (pk_req),
        .ptr (pk_ptr),
        .any (pk_any),
        .idx (pk_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction with out_ready=1, starting from ARB with the winner's req visible.
    task automatic do_txn(input logic [2:0] w, input logic [2:0] data);
        logic [7:0] eg;
        eg = 8'h01 << w;
        step();
        chk("load_gnt", 32'(gnt), 32'(eg));
        chk("load_sel3", 32'(sel3), 32'(w));
        chk("load_src", 32'(out_src), 32'(w));
        chk("load_valid", 32'(out_valid), 32'd0);
        step();
        chk("send_valid", 32'(out_valid), 32'd1);
        chk("send_data", 32'(out_data), 32'(data));
        chk("send_src", 32'(out_src), 32'(w));
        chk("send_gnt", 32'(gnt), 32'd0);
        step();
        chk("arb_valid", 32'(out_valid), 32'd0);
        chk("arb_gnt", 32'(gnt), 32'd0);
    endtask

    initial begin
        logic [2:0] in_tab [8];
        logic       pending [8];
        int         wcnt [8];
        logic [5:0] expq [$];
        logic [5:0] e;
        int         w;

        in_tab = '{3'd3, 3'd0, 3'd5, 3'd2, 3'd7, 3'd4, 3'd1, 3'd6};
        for (int i = 0; i < 8; i++) in_data[i] = in_tab[i];

        // rr_pick8 standalone
        pk_req = 8'h00; pk_ptr = 3'd3; #1;
        chk("pick_none_any", 32'(pk_any), 32'd0);
        pk_req = 8'h81; pk_ptr = 3'd1; #1;
        chk("pick_81_p1", 32'(pk_idx), 32'd7);
        chk("pick_81_any", 32'(pk_any), 32'd1);
        pk_req = 8'h81; pk_ptr = 3'd0; #1;
        chk("pick_81_p0", 32'(pk_idx), 32'd0);
        pk_req = 8'hFF; pk_ptr = 3'd5; #1;
        chk("pick_ff_p5", 32'(pk_idx), 32'd5);
        pk_req = 8'h06; pk_ptr = 3'd7; #1;
        chk("pick_06_p7", 32'(pk_idx), 32'd1);
        pk_req = 8'h10; pk_ptr = 3'd5; #1;
        chk("pick_10_p5", 32'(pk_idx), 32'd4);

        // Reset state, then all requesting: winners 0..7,0
        rst_n = 1'b0; req = 8'hFF; out_ready = 1'b1;
        step(); step();
        chk("rst_sel3", 32'(sel3), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) do_txn(3'(k % 8), in_tab[k % 8]);

        // Two requesters at the ends: 0, 7, then wrap back to 0
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req = 8'h81;
        do_txn(3'd0, in_tab[0]);
        do_txn(3'd7, in_tab[7]);
        do_txn(3'd0, in_tab[0]);

        // Idle holds sel3, then single requester 5
        req = 8'h00;
        step(); step(); step();
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_sel3", 32'(sel3), 32'd0);
        in_data[5] = 3'b110;
        req = 8'h20;
        do_txn(3'd5, 3'b110);

        // Backpressure on requester 6
        req = 8'h40; out_ready = 1'b0;
        step();
        chk("bp_gnt", 32'(gnt), 32'h40);
        step();
        chk("bp_valid0", 32'(out_valid), 32'd1);
        chk("bp_data0", 32'(out_data), 32'(in_tab[6]));
        req = 8'hBF;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'(in_tab[6]));
            chk("bp_src", 32'(out_src), 32'd6);
            chk("bp_nogrant", 32'(gnt), 32'd0);
        end
        req = 8'h00; out_ready = 1'b1;
        step();
        chk("bp_release", 32'(out_valid), 32'd0);
        step();
        chk("bp_idle_gnt", 32'(gnt), 32'd0);

        // Async reset in LOAD; afterwards ptr must be 0 (0x90 -> 4, not 7)
        req = 8'h04;
        step();
        chk("ar_gnt", 32'(gnt), 32'h04);
        chk("ar_sel3", 32'(sel3), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_gnt0", 32'(gnt), 32'd0);
        chk("ar_valid0", 32'(out_valid), 32'd0);
        chk("ar_sel0", 32'(sel3), 32'd0);
        chk("ar_src0", 32'(out_src), 32'd0);
        step();
        rst_n = 1'b1;
        req = 8'h90;
        do_txn(3'd4, in_tab[4]);

        // Random requests and backpressure with a protocol-abiding requester model
        req = 8'h00;
        for (int i = 0; i < 8; i++) begin pending[i] = 1'b0; wcnt[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            step();
            chk("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
            if (gnt != 8'h00) begin
                w = 0;
                for (int i = 0; i < 8; i++) if (gnt[i]) w = i;
                chk("rnd_gnt_pending", 32'(pending[w]), 32'd1);
                chk("rnd_wait_bound", 32'(wcnt[w] <= 7), 32'd1);
                for (int i = 0; i < 8; i++) if (pending[i] && i != w) wcnt[i]++;
                pending[w] = 1'b0;
                wcnt[w]    = 0;
                req[w]     = 1'b0;
                expq.push_back({in_data[w], 3'(w)});
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                chk("rnd_q_nonempty", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("rnd_data", 32'(out_data), 32'(e[5:3]));
                    chk("rnd_src", 32'(out_src), 32'(e[2:0]));
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (!pending[i] && !gnt[i] && $urandom_range(0, 3) == 0) begin
                    in_data[i] = 3'($urandom_range(0, 7));
                    req[i]     = 1'b1;
                    pending[i] = 1'b1;
                    wcnt[i]    = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
